// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared constants and FSM encoding for the instruction-fetch stage.
package if_stage_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {IF_BOOT = 2'd0, IF_RUN = 2'd1, IF_TRAP = 2'd2} if_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular FIFO with occupancy count; flush wins over push and pop.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rp];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? nxt(wp) : wp;
      rp <= do_pop ? nxt(rp) : rp;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wp] <= wdata;
endmodule

// File: rtl/if_stage.sv
// if_stage: fetch PC, credit-limited imem issue, in-order tag queue, redirect discard, decode output register.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirect targets park the stage in TRAP with fetch_misaligned.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                   WORD_SIZE  = 32,
  parameter int                   ADDR_SIZE  = 10,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 imem_req,
  output logic [ADDR_SIZE-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  output logic [WORD_SIZE-1:0] instr,
  output logic [WORD_SIZE-1:0] pc_out,
  output logic [WORD_SIZE-1:0] pc_plus4,
  output logic                 instr_valid
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic                 fetch_misaligned
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [WORD_SIZE-1:0] NOP = WORD_SIZE'(NOP_INSTR);
  if_state_e state;
  logic [WORD_SIZE-1:0] fetch_pc, tgt, tag_pc, head_pc, head_instr;
  logic [2*WORD_SIZE-1:0] head;
  logic [CW-1:0] outstanding, buf_count, discard;
  logic [CW:0] used;
  logic tag_full, tag_empty, buf_full, buf_empty;
  logic transfer, drop, push_buf, pop_buf, misaligned;
`ifdef IF_MISALIGN_TRAP_EN
  assign misaligned = |redirect_pc[1:0];
  assign fetch_misaligned = state == IF_TRAP;
`else
  assign misaligned = 1'b0;
`endif
  assign tgt = redirect_pc & ~WORD_SIZE'(3);
  assign imem_addr = fetch_pc[ADDR_SIZE+1:2];
  assign pc_plus4 = pc_out + WORD_SIZE'(4);
  assign {head_pc, head_instr} = head;
  assign pop_buf = !redirect && !stall && !buf_empty;
  // a head popped this edge frees its slot, which keeps zero-wait fetch at one per cycle
  assign used = (CW+1)'(outstanding) + (CW+1)'(buf_count) - (CW+1)'(pop_buf);
  assign imem_req = state == IF_RUN && !redirect && used < (CW+1)'(FIFO_DEPTH);
  assign transfer = imem_req && imem_gnt;
  assign drop = imem_rvalid && (redirect || discard != '0);
  assign push_buf = imem_rvalid && !drop;
  fetch_fifo #(.WIDTH(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_tags (
    .clk(clk), .rst(rst), .push(transfer), .pop(imem_rvalid), .flush(1'b0),
    .wdata(fetch_pc), .rdata(tag_pc), .count(outstanding), .full(tag_full), .empty(tag_empty)
  );
  fetch_fifo #(.WIDTH(2*WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk(clk), .rst(rst), .push(push_buf), .pop(pop_buf), .flush(redirect),
    .wdata({tag_pc, imem_rdata}), .rdata(head), .count(buf_count), .full(buf_full), .empty(buf_empty)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IF_BOOT;
      fetch_pc <= RESET_PC;
      discard <= '0;
      instr <= NOP;
      pc_out <= RESET_PC;
      instr_valid <= 1'b0;
    end else begin
      state <= redirect ? (misaligned ? IF_TRAP : IF_RUN) : (state == IF_TRAP ? IF_TRAP : IF_RUN);
      fetch_pc <= redirect ? tgt : transfer ? fetch_pc + WORD_SIZE'(4) : fetch_pc;
      // every request still in flight after a redirect belongs to the old path
      discard <= redirect ? outstanding - CW'(imem_rvalid)
               : (imem_rvalid && discard != '0) ? discard - 1'b1 : discard;
      if (redirect || !stall) begin
        instr <= pop_buf ? head_instr : NOP;
        pc_out <= pop_buf ? head_pc : pc_out;
        instr_valid <= pop_buf;
      end
    end
  assert property (@(posedge clk) disable iff (!rst) !(push_buf && buf_full && !pop_buf));
  assert property (@(posedge clk) disable iff (!rst) !(imem_rvalid && tag_empty));
  assert property (@(posedge clk) disable iff (!rst) !(transfer && tag_full && !imem_rvalid));
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized fetch scenarios against a transaction-level model
// (in-order request queue with redirect epochs, buffered-PC queue, expected fetch address).
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst = 1, stall = 0, redirect = 0, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0, instr, pc_out, pc_plus4;
  logic imem_req, instr_valid;
  logic [9:0] imem_addr;
`ifdef IF_MISALIGN_TRAP_EN
  logic fetch_misaligned;
`endif
  always #5 clk = ~clk;
  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .instr_valid(instr_valid)
`ifdef IF_MISALIGN_TRAP_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );
  typedef struct { logic [31:0] pc; int ep; int rdy; } req_t;
  req_t rq[$];
  logic [31:0] bq[$], vlog[$];
  int vcyc[$];
  int errors = 0, checks = 0, cyc = 0, epoch = 0, dly_lo = 0, dly_hi = 0, first_g = -1, first_v = -1;
  logic [31:0] mfetch = 0, e_instr = NOP, e_pc = 0, a0;
  logic e_valid = 0, s_req = 0, wait_prev = 0, ready;
  logic [9:0] prev_addr = 0;
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hA5C3, ~pc[17:2]};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic do_reset();
    rst = 0;
    stall = 0;
    redirect = 0;
    imem_gnt = 0;
    imem_rvalid = 0;
    rq.delete();
    bq.delete();
    mfetch = 0;
    e_valid = 0;
    e_instr = NOP;
    wait_prev = 0;
    epoch++;
    #1;
    check("rst_valid", {31'b0, instr_valid}, 0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc_out, 0);
    check("rst_link", pc_plus4, 4);
    check("rst_req", {31'b0, imem_req}, 0);
    @(negedge clk);
    rst = 1;
  endtask
  // one clock cycle: starts and ends at a falling edge
  task automatic tick(input logic st, input logic rd, input logic [31:0] rpc, input logic g);
    req_t r;
    logic rv, xfer;
    if (instr_valid) begin
      vlog.push_back(pc_out);
      vcyc.push_back(cyc - 1);
      if (first_v < 0) first_v = cyc - 1;
    end
    check("valid", {31'b0, instr_valid}, {31'b0, e_valid});
    check("instr", instr, e_instr);
    if (e_valid) check("pc", pc_out, e_pc);
    check("link", pc_plus4, pc_out + 32'd4);
    stall = st;
    redirect = rd;
    redirect_pc = rpc;
    imem_gnt = g;
    rv = rq.size() > 0 && rq[0].rdy <= cyc;
    imem_rvalid = rv;
    imem_rdata = rv ? mem_word(rq[0].pc) : $urandom;
    #1;
    s_req = imem_req;
    if (wait_prev && !rd) begin
      check("req_hold", {31'b0, imem_req}, 1);
      check("addr_hold", 32'(imem_addr), 32'(prev_addr));
    end
    if (rd) check("req_redirect", {31'b0, imem_req}, 0);
    if (imem_req) check("addr", 32'(imem_addr), 32'(mfetch[11:2]));
    xfer = imem_req && g;
    wait_prev = imem_req && !g;
    prev_addr = imem_addr;
    if (xfer && first_g < 0) first_g = cyc;
    @(posedge clk);
    if (rd || !st) begin
      e_valid = !rd && bq.size() > 0;
      if (e_valid) e_pc = bq.pop_front();
      e_instr = e_valid ? mem_word(e_pc) : NOP;
    end
    if (rv) begin
      r = rq.pop_front();
      if (!rd && r.ep == epoch) bq.push_back(r.pc);
    end
    if (rd) begin
      bq.delete();
      epoch++;
      mfetch = rpc & ~32'd3;
    end else if (xfer) begin
      r.pc = mfetch;
      r.ep = epoch;
      r.rdy = cyc + 1 + int'($urandom_range(dly_hi, dly_lo));
      rq.push_back(r);
      mfetch += 4;
    end
    check("credit", {31'b0, rq.size() + bq.size() <= 2}, 1);
    cyc++;
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    tick(0, 0, 0, 1);
    check("boot_req", {31'b0, s_req}, 0);
    tick(0, 0, 0, 1);
    check("run_req", {31'b0, s_req}, 1);
    repeat (10) tick(0, 0, 0, 1);
    check("latency", 32'(first_v - first_g), 2);
    check("stream_len", {31'b0, vlog.size() >= 4}, 1);
    for (int k = 0; k < 4; k++) begin
      check("stream_pc", vlog[k], 32'(4 * k));
      check("stream_cyc", 32'(vcyc[k] - vcyc[0]), 32'(k));
    end
    repeat (5) tick(1, 0, 0, 1);
    check("stall_credit", {31'b0, s_req}, 0);
    vlog.delete();
    repeat (6) tick(0, 0, 0, 1);
    check("resume_seq", vlog[1] - vlog[0], 4);
    dly_lo = 3;
    dly_hi = 3;
    for (int i = 0; i < 12 && rq.size() < 2; i++) tick(0, 0, 0, 1);
    check("t3_outstanding", 32'(rq.size()), 2);
    tick(0, 1, 32'h100, 1);
    dly_lo = 0;
    dly_hi = 0;
    vlog.delete();
    repeat (12) tick(0, 0, 0, 1);
    check("t3_first", vlog[0], 32'h100);
    check("t3_second", vlog[1], 32'h104);
    dly_lo = 1;
    dly_hi = 1;
    ready = 0;
    for (int i = 0; i < 12 && !ready; i++) begin
      tick(0, 0, 0, 1);
      ready = rq.size() > 0 && rq[0].rdy <= cyc;
    end
    check("t4_rvalid", {31'b0, ready}, 1);
    tick(1, 1, 32'h300, 1);
    check("t4_nop", {31'b0, instr_valid}, 0);
    dly_lo = 0;
    dly_hi = 0;
    vlog.delete();
    repeat (8) tick(0, 0, 0, 1);
    check("t4_first", vlog[0], 32'h300);
    s_req = 0;
    for (int i = 0; i < 10 && !s_req; i++) tick(0, 0, 0, 0);
    a0 = 32'(prev_addr);
    repeat (3) begin
      tick(0, 0, 0, 0);
      check("t5_req", {31'b0, s_req}, 1);
      check("t5_addr", 32'(prev_addr), a0);
    end
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    if (s_req) check("t5_advance", 32'(prev_addr), a0 + 1);
`ifdef IF_MISALIGN_TRAP_EN
    tick(0, 1, 32'h102, 1);
    repeat (4) begin
      tick(0, 0, 0, 1);
      check("trap_req", {31'b0, s_req}, 0);
      check("trap_flag", {31'b0, fetch_misaligned}, 1);
    end
    tick(0, 1, 32'h200, 1);
    vlog.delete();
    repeat (8) tick(0, 0, 0, 1);
    check("trap_clear", {31'b0, fetch_misaligned}, 0);
    check("trap_resume", vlog[0], 32'h200);
`else
    tick(0, 1, 32'h202, 1);
    vlog.delete();
    repeat (8) tick(0, 0, 0, 1);
    check("lowbits_ignored", vlog[0], 32'h200);
`endif
    vlog.delete();
    dly_hi = 3;
    for (int i = 0; i < 400; i++)
      tick($urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0,
           {22'b0, 8'($urandom), 2'b00}, $urandom_range(9, 0) < 7);
    check("rand_progress", {31'b0, vlog.size() > 50}, 1);
    do_reset();
    dly_hi = 0;
    vlog.delete();
    repeat (8) tick(0, 0, 0, 1);
    check("reset_restart", vlog[0], 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
